// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: loader FSM state encoding and the default memory geometry
// shared between the boot loader and instr_mem.
package imem_boot_loader_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CYC_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_checksum.sv
// loader_checksum: running modular sum of image data words, compared against a
// captured checksum word. Used by imem_boot_loader only when LOADER_CSUM_EN is defined.
module loader_checksum
    import imem_boot_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_data,
    output logic              pass
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] expected;

    // The sum wraps naturally at DATA_W bits, giving the modulo-2**DATA_W checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum      <= '0;
            expected <= '0;
        end else begin
            if (clear) begin
                sum      <= '0;
                expected <= '0;
            end else begin
                if (add_en) begin
                    sum <= sum + add_data;
                end
                if (cap_en) begin
                    expected <= cap_data;
                end
            end
        end
    end

    assign pass = (sum == expected);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instr_mem, then releases cpu reset
// and counts run cycles. Define LOADER_CSUM_EN to treat the s_last word as a checksum.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CYC_W  = DEF_CYC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_cnt,
    output logic [CYC_W-1:0]  run_cycles
);

    localparam logic [ADDR_W:0]  FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;

    loader_state_t state;
    loader_state_t state_next;

    logic xfer;
    logic full;
    logic write_en;
    logic overflow;
    logic load_begin;
    logic running;

    assign s_ready = (state == ST_LOAD);
    assign busy    = (state == ST_LOAD) || (state == ST_CHECK);
    assign error   = (state == ST_ERROR);
    assign xfer    = s_valid && s_ready;
    assign full    = (word_cnt == FULL_CNT);

`ifdef LOADER_CSUM_EN
    logic csum_pass;

    // A checksum word arriving at a full count is legal: it never touches memory.
    assign write_en = xfer && !s_last && !full;
    assign overflow = xfer && !s_last && full;

    loader_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_begin),
        .add_en   (write_en),
        .add_data (s_data),
        .cap_en   (xfer && s_last),
        .cap_data (s_data),
        .pass     (csum_pass)
    );
`else
    assign write_en = xfer && !full;
    assign overflow = xfer && full;
`endif

    assign load_begin = (state_next == ST_LOAD) && (state != ST_LOAD);
    assign running    = (state == ST_RUN) && (state_next == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (overflow) begin
                    state_next = ST_ERROR;
                end else if (xfer && s_last) begin
`ifdef LOADER_CSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_RUN;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            // An image consisting of only the checksum word is empty and rejected.
            ST_CHECK: begin
                state_next = ((word_cnt != '0) && csum_pass) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
        end else begin
            imem_we <= write_en;
            if (write_en) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= s_data;
            end
            if (load_begin) begin
                word_cnt <= '0;
            end else if (write_en) begin
                word_cnt <= word_cnt + CNT_ONE;
            end
        end
    end

    // cpu_rst is registered from the current state, so it falls one cycle after
    // entering RUN, i.e. after the final imem write has already been presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            run_cycles <= '0;
        end else begin
            cpu_rst <= !running;
            done    <= running;
            if (load_begin) begin
                run_cycles <= '0;
            end else if (running && !cpu_rst && (run_cycles != CYC_MAX)) begin
                run_cycles <= run_cycles + CYC_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader with a small 8-word memory
// and an 8-bit run counter; LOADER_CSUM_EN selects the checksum stimulus.
module tb_imem_boot_loader;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int CYC_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_cnt;
    logic [CYC_W-1:0]  run_cycles;

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;
    bit mon_en = 1'b0;
    logic [ADDR_W-1:0] sb_addr[$];
    logic [DATA_W-1:0] sb_data[$];
    logic [DATA_W-1:0] image[$];

    imem_boot_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CYC_W  (CYC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_cnt   (word_cnt),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Every accepted data word must appear as exactly one write on the following cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("imem_we", imem_we, sb_addr.size() != 0);
            if (imem_we && sb_addr.size() != 0) begin
                checkOutput("imem_addr", imem_addr, sb_addr.pop_front());
                checkOutput("imem_wdata", imem_wdata, sb_data.pop_front());
            end
        end
    end

    task automatic checkResetValues();
        checkOutput("rst_cpu_rst", cpu_rst, 1'b1);
        checkOutput("rst_s_ready", s_ready, 1'b0);
        checkOutput("rst_imem_we", imem_we, 1'b0);
        checkOutput("rst_imem_addr", imem_addr, 0);
        checkOutput("rst_imem_wdata", imem_wdata, 0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        checkOutput("rst_run_cycles", run_cycles, 0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_cnt = 0;
        #1;
        checkOutput("start_cpu_rst", cpu_rst, 1'b1);
        checkOutput("start_busy", busy, 1'b1);
        checkOutput("start_done", done, 1'b0);
        checkOutput("start_error", error, 1'b0);
        checkOutput("start_word_cnt", word_cnt, 0);
        checkOutput("start_run_cycles", run_cycles, 0);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last, input bit writes, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        #1 checkOutput("s_ready", s_ready, 1'b1);
        @(posedge clk);
        if (writes) begin
            sb_addr.push_back(model_cnt[ADDR_W-1:0]);
            sb_data.push_back(data);
            model_cnt++;
        end
    endtask

    task automatic loadImage(input int n, input int gap_max, input int poke_at);
`ifdef LOADER_CSUM_EN
        logic [DATA_W-1:0] sum;
        sum = '0;
`endif
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
                start   = 1'b1;
                @(negedge clk);
                start = 1'b0;
                #1;
                checkOutput("start_in_load_cnt", word_cnt, model_cnt);
                checkOutput("start_in_load_busy", busy, 1'b1);
            end
`ifdef LOADER_CSUM_EN
            applyStimulus(image[i], 1'b0, 1'b1, $urandom_range(gap_max, 0));
            sum = sum + image[i];
`else
            applyStimulus(image[i], (i == n - 1), 1'b1, $urandom_range(gap_max, 0));
`endif
        end
`ifdef LOADER_CSUM_EN
        applyStimulus(sum, 1'b1, 1'b0, 0);
`endif
    endtask

    task automatic expectRun(input int words);
        for (int k = 0; k <= EXTRA; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            #1;
            checkOutput("cpu_rst_hold", cpu_rst, 1'b1);
            checkOutput("done_early", done, 1'b0);
        end
        @(negedge clk);
        #1;
        checkOutput("cpu_rst_release", cpu_rst, 1'b0);
        checkOutput("done", done, 1'b1);
        checkOutput("busy_run", busy, 1'b0);
        checkOutput("word_cnt", word_cnt, words);
        checkOutput("run_cycles_start", run_cycles, 0);
    endtask

    task automatic checkRunFor(input int cycles);
        int exp_cyc;
        exp_cyc = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            exp_cyc = (exp_cyc == (1 << CYC_W) - 1) ? exp_cyc : exp_cyc + 1;
            #1 checkOutput("run_cycles", run_cycles, exp_cyc);
        end
    endtask

    task automatic expectError(input int words);
        #1;
        checkOutput("err_error", error, 1'b1);
        checkOutput("err_cpu_rst", cpu_rst, 1'b1);
        checkOutput("err_s_ready", s_ready, 1'b0);
        checkOutput("err_done", done, 1'b0);
        checkOutput("err_busy", busy, 1'b0);
        checkOutput("err_word_cnt", word_cnt, words);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2 rst = 1'b0;
        #1 checkResetValues();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 mon_en = 1'b1;

        // Stream words presented while idle are neither accepted nor written.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'hdeadbeef;
        s_last  = 1'b1;
        #1 checkOutput("idle_s_ready", s_ready, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1 checkOutput("idle_busy", busy, 1'b0);

        $display("[TB] basic 4-word load");
        image = '{32'h00500513, 32'h00100593, 32'h02b50533, 32'hfff58593};
        pulseStart();
        loadImage(4, 0, -1);
        expectRun(4);
        checkRunFor(3);

        $display("[TB] gapped load with ignored start");
        image.delete();
        for (int i = 0; i < 6; i++) image.push_back($urandom());
        pulseStart();
        loadImage(6, 3, 3);
        expectRun(6);

        $display("[TB] overflow");
        pulseStart();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(32'h1000 + i, 1'b0, (i < DEPTH), $urandom_range(1, 0));
        end
        @(negedge clk);
        s_valid = 1'b0;
        expectError(DEPTH);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h5555aaaa;
        #1 checkOutput("error_s_ready", s_ready, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;

        $display("[TB] full image");
        image.delete();
        for (int i = 0; i < DEPTH; i++) image.push_back(32'hc0de0000 + i);
        pulseStart();
        loadImage(DEPTH, 1, -1);
        expectRun(DEPTH);

        $display("[TB] one-word image");
        image = '{32'h0000006f};
        pulseStart();
        loadImage(1, 0, -1);
        expectRun(1);

        $display("[TB] async reset mid-load");
        pulseStart();
        applyStimulus(32'haaaa0001, 1'b0, 1'b1, 0);
        applyStimulus(32'haaaa0002, 1'b0, 1'b1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1 checkResetValues();
        sb_addr.delete();
        sb_data.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        #1 mon_en = 1'b1;
        image = '{32'h11111111, 32'h22222222, 32'h33333333};
        pulseStart();
        loadImage(3, 1, -1);
        expectRun(3);

`ifdef LOADER_CSUM_EN
        $display("[TB] checksum pass, fail, empty");
        image = '{32'd1, 32'd2, 32'd3};
        pulseStart();
        loadImage(3, 0, -1);
        expectRun(3);
        pulseStart();
        applyStimulus(32'd1, 1'b0, 1'b1, 0);
        applyStimulus(32'd2, 1'b0, 1'b1, 0);
        applyStimulus(32'd3, 1'b0, 1'b1, 0);
        applyStimulus(32'd7, 1'b1, 1'b0, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1 checkOutput("check_busy", busy, 1'b1);
        @(negedge clk);
        expectError(3);
        pulseStart();
        applyStimulus(32'd0, 1'b1, 1'b0, 0);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        expectError(0);
        image = '{32'h0000006f};
        pulseStart();
        loadImage(1, 0, -1);
        expectRun(1);
`endif

        $display("[TB] run counter saturation and restart");
        checkRunFor(260);
        pulseStart();
        @(negedge clk);
        checkOutput("sb_drained", sb_addr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
